// File: rtl/div_unit_pkg.sv
// Shared types, constants and sign helpers for the RV32M iterative divider.
package div_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  function automatic logic [XLEN-1:0] neg_val(input logic [XLEN-1:0] x);
    return ~x + XLEN'(1);
  endfunction

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? neg_val(x) : x;
  endfunction
endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the pipeline and the divider.
interface div_unit_intf
  import div_pkg::*;
#(
  parameter int WIDTH = XLEN
);
  logic             start;
  div_op_e          op;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic [4:0]       rd_addr;
  logic             busy;
  logic             done;
  logic [4:0]       done_rd;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, rs1_data, rs2_data, rd_addr,
    input  busy, done, done_rd, result
  );

  modport slave (
    input  start, op, rs1_data, rs2_data, rd_addr,
    output busy, done, done_rd, result
  );

  modport monitor (
    input start, op, rs1_data, rs2_data, rd_addr,
    input busy, done, done_rd, result
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// RISC-V special cases (divide by zero, signed overflow) bypass the iteration.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic        clk,
  input  logic        rst,
  div_unit_intf.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  div_op_e          op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             done_q, done_d;
  logic [4:0]       done_rd_q, done_rd_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             is_signed, sign1, sign2, div_zero, overflow, rem_ge;
  logic [WIDTH:0]   rem_tmp;

  always_comb begin
    is_signed = (bus.op == DIV) || (bus.op == REM);
    sign1     = is_signed & bus.rs1_data[WIDTH-1];
    sign2     = is_signed & bus.rs2_data[WIDTH-1];
    div_zero  = (bus.rs2_data == '0);
    overflow  = is_signed && (bus.rs1_data == INT_MIN) && (bus.rs2_data == ALL_ONES);
    rem_tmp   = {rem_q, dvd_q[WIDTH-1]};
    rem_ge    = (rem_tmp >= {1'b0, dsr_q});

    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    done_rd_d = done_rd_q;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        // The done pulse lands while the FSM is already back in IDLE; a start
        // seen in that cycle still belongs to the finishing DONE phase.
        if (bus.start && !done_q) begin
          op_d  = bus.op;
          rd_d  = bus.rd_addr;
          cnt_d = '0;
          dsr_d = is_signed ? abs_val(bus.rs2_data) : bus.rs2_data;
          if (div_zero || overflow) begin
            dvd_d     = div_zero ? ALL_ONES : INT_MIN;
            rem_d     = div_zero ? bus.rs1_data : '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = DONE;
          end else begin
            dvd_d     = is_signed ? abs_val(bus.rs1_data) : bus.rs1_data;
            rem_d     = '0;
            neg_quo_d = sign1 ^ sign2;
            neg_rem_d = sign1;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        // Quotient bits shift into the vacated dividend LSBs.
        dvd_d = {dvd_q[WIDTH-2:0], rem_ge};
        rem_d = rem_ge ? (rem_tmp[WIDTH-1:0] - dsr_q) : rem_tmp[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = DONE;
      end
      DONE: begin
        state_d   = IDLE;
        done_d    = 1'b1;
        done_rd_d = rd_q;
        if (op_q == DIV || op_q == DIVU) result_d = neg_quo_q ? neg_val(dvd_q) : dvd_q;
        else                             result_d = neg_rem_q ? neg_val(rem_q) : rem_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= DIV;
      rd_q      <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      done_rd_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
      done_rd_q <= done_rd_d;
      result_q  <= result_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.done_rd = done_rd_q;
  assign bus.result  = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_div_unit;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  div_unit_intf #(.WIDTH(32)) bus ();
  div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic is_special(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = (op == DIV) || (op == REM);
    return (b == 32'h0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return (op == DIV || op == DIVU) ? 32'hFFFF_FFFF : a;
    if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (op == DIV) ? 32'h8000_0000 : 32'h0;
    case (op)
      DIV:     return sa / sb;
      REM:     return sa % sb;
      DIVU:    return a / b;
      default: return a % b;
    endcase
  endfunction

  task automatic launch(input div_op_e op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_addr  = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Called #1 after the start edge; returns with done sampled high (or timed out).
  task automatic wait_done(input string tag, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (lat < 100) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
    end
    if (!bus.done) check({tag, "_timeout"}, 32'(bus.done), 32'd1);
  endtask

  task automatic run_op(input string tag, input div_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    int lat, busy_cnt, exp_lat;
    logic [31:0] exp;
    exp     = ref_result(op, a, b);
    exp_lat = is_special(op, a, b) ? 1 : 33;
    launch(op, a, b, rd);
    wait_done(tag, lat, busy_cnt);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busycnt"}, 32'(busy_cnt), 32'(exp_lat));
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_done_rd"}, 32'(bus.done_rd), 32'(rd));
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_hold"}, bus.result, exp);
  endtask

  initial begin
    int lat, busy_cnt;
    div_op_e op;
    logic [31:0] a, b;

    bus.start    = 1'b0;
    bus.op       = DIVU;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.rd_addr  = '0;

    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_done_rd", 32'(bus.done_rd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 5'd5);
    run_op("remu_100_7", REMU, 32'd100, 32'd7, 5'd5);
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 5'd1);
    run_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 5'd2);
    run_op("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE, 5'd3);
    run_op("divu_z", DIVU, 32'h1234_5678, 32'd0, 5'd4);
    run_op("remu_z", REMU, 32'h1234_5678, 32'd0, 5'd6);
    run_op("div_z", DIV, 32'h1234_5678, 32'd0, 5'd7);
    run_op("rem_z", REM, 32'h1234_5678, 32'd0, 5'd8);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op("divu_ovf", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    run_op("rd0", DIVU, 32'd50, 32'd5, 5'd0);

    // Start while busy is ignored.
    launch(DIVU, 32'd100, 32'd7, 5'd5);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    bus.start    = 1'b1;
    bus.rs1_data = 32'd9;
    bus.rs2_data = 32'd3;
    bus.rd_addr  = 5'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("busy_ign", lat, busy_cnt);
    check("busy_ign_result", bus.result, 32'd14);
    check("busy_ign_done_rd", 32'(bus.done_rd), 32'd5);

    // Start in the done cycle is ignored.
    bus.start    = 1'b1;
    bus.op       = DIVU;
    bus.rs1_data = 32'd9;
    bus.rs2_data = 32'd0;
    bus.rd_addr  = 5'd13;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("done_ign_busy", 32'(bus.busy), 32'd0);
    check("done_ign_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    check("done_ign_nodone", 32'(bus.done), 32'd0);
    check("done_ign_result", bus.result, 32'd14);

    // Async reset mid-calculation.
    launch(DIVU, 32'd100, 32'd7, 5'd5);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    check("midrst_done_rd", 32'(bus.done_rd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) break;
    end
    check("midrst_quiet", {30'd0, bus.busy, bus.done}, 32'd0);
    run_op("after_rst", DIVU, 32'd9, 32'd3, 5'd4);

    for (int i = 0; i < 40; i++) begin
      op = div_op_e'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = $urandom_range(1, 16);
        3:       b = -$urandom_range(1, 16);
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), op, a, b, 5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
